// File: rtl/bus_target_pkg.sv
// rtl/bus_target_pkg.sv - shared FSM state, register offsets and CTRL bit indices for cpu_bus_target
package bus_target_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0] OFS_RELOAD = 8'h10;
    localparam logic [7:0] OFS_CTRL   = 8'h11;
    localparam logic [7:0] OFS_STATUS = 8'h12;
    localparam logic [7:0] OFS_COUNT  = 8'h13;

    localparam int CTRL_TMR_EN = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STATUS_PEND = 0;

endpackage

// File: rtl/irq_timer.sv
// rtl/irq_timer.sv - interval timer with reload, sticky pending and registered IRQ (CPU_BUS_TARGET_TIMER_EN)
`ifdef CPU_BUS_TARGET_TIMER_EN
module irq_timer
    import bus_target_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       reload_we_i,
    input  logic       ctrl_we_i,
    input  logic       status_clr_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] reload_o,
    output logic [7:0] ctrl_o,
    output logic [7:0] count_o,
    output logic       pending_o,
    output logic       irq_o
);

    logic [7:0] reload_q, reload_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic [7:0] count_q, count_d;
    logic       pending_q, pending_d;
    logic       irq_q, irq_d;
    logic       expire;

    always_comb begin
        reload_d  = reload_q;
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        expire    = ctrl_q[CTRL_TMR_EN] && (count_q == 8'h00);
        if (reload_we_i) begin
            reload_d = wdata_i;
        end
        if (ctrl_we_i) begin
            ctrl_d = wdata_i[1:0];
        end
        // A RELOAD write takes priority over the running count.
        if (reload_we_i) begin
            count_d = wdata_i;
        end else if (ctrl_q[CTRL_TMR_EN]) begin
            count_d = expire ? reload_q : count_q - 8'd1;
        end
        // Expiry beats a software clear landing on the same edge.
        pending_d = expire | (pending_q & ~status_clr_i);
        irq_d     = pending_q & ctrl_q[CTRL_IRQ_EN];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reload_q  <= 8'h00;
            ctrl_q    <= 2'b00;
            count_q   <= 8'h00;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            reload_q  <= reload_d;
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign reload_o  = reload_q;
    assign ctrl_o    = {6'b000000, ctrl_q};
    assign count_o   = count_q;
    assign pending_o = pending_q;
    assign irq_o     = irq_q;

endmodule
`endif

// File: rtl/cpu_bus_target.sv
// rtl/cpu_bus_target.sv - CPU bus responder: scratch RAM, wait-state FSM, optional timer (CPU_BUS_TARGET_TIMER_EN)
module cpu_bus_target
    import bus_target_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hFE00,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] ADDRESS,
    input  logic        RW,
    input  logic [7:0]  WDATA,
    output logic [7:0]  RDATA,
    output logic        DRIVE,
    output logic        RDY,
    output logic        IRQ
);

    localparam logic [2:0] WS = WAIT_STATES[2:0];

    state_e     state_q, state_d;
    logic [7:0] ofs_q, ofs_d;
    logic       rw_q, rw_d;
    logic [7:0] wdata_q, wdata_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] ram_q [16];
    logic       hit;
    logic       commit;
    logic [7:0] ofs_nxt;
    logic [7:0] rd_val;

    assign hit    = (ADDRESS[15:8] == BASE_ADDR[15:8]);
    assign commit = (state_q == ST_DONE) && !rw_q;
    // With zero wait states the read is captured on the same edge the offset is latched.
    assign ofs_nxt = (state_q == ST_IDLE) ? ADDRESS[7:0] : ofs_q;

`ifdef CPU_BUS_TARGET_TIMER_EN
    logic [7:0] tmr_reload;
    logic [7:0] tmr_ctrl;
    logic [7:0] tmr_count;
    logic       tmr_pending;

    irq_timer u_irq_timer (
        .clk_i        (CLK),
        .rst_ni       (RST_N),
        .reload_we_i  (commit && (ofs_q == OFS_RELOAD)),
        .ctrl_we_i    (commit && (ofs_q == OFS_CTRL)),
        .status_clr_i (commit && (ofs_q == OFS_STATUS) && wdata_q[STATUS_PEND]),
        .wdata_i      (wdata_q),
        .reload_o     (tmr_reload),
        .ctrl_o       (tmr_ctrl),
        .count_o      (tmr_count),
        .pending_o    (tmr_pending),
        .irq_o        (IRQ)
    );
`else
    assign IRQ = 1'b0;
`endif

    always_comb begin
        rd_val = 8'h00;
        if (ofs_nxt[7:4] == 4'h0) begin
            rd_val = ram_q[ofs_nxt[3:0]];
        end
`ifdef CPU_BUS_TARGET_TIMER_EN
        else if (ofs_nxt == OFS_RELOAD) begin
            rd_val = tmr_reload;
        end else if (ofs_nxt == OFS_CTRL) begin
            rd_val = tmr_ctrl;
        end else if (ofs_nxt == OFS_STATUS) begin
            rd_val = {7'b0000000, tmr_pending};
        end else if (ofs_nxt == OFS_COUNT) begin
            rd_val = tmr_count;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        ofs_d   = ofs_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    ofs_d   = ADDRESS[7:0];
                    rw_d    = RW;
                    wdata_d = WDATA;
                    if (WS == 3'd0) begin
                        state_d = ST_DONE;
                        rdata_d = rd_val;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = ST_DONE;
                    rdata_d = rd_val;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            ofs_q   <= 8'h00;
            rw_q    <= 1'b1;
            wdata_q <= 8'h00;
            cnt_q   <= 3'd0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            ofs_q   <= ofs_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Scratch RAM has no reset; contents are undefined until written.
    always_ff @(posedge CLK) begin
        if (commit && (ofs_q[7:4] == 4'h0)) begin
            ram_q[ofs_q[3:0]] <= wdata_q;
        end
    end

    assign RDY   = !(((state_q == ST_IDLE) && hit) || (state_q == ST_WAIT));
    assign DRIVE = (state_q == ST_DONE) && rw_q;
    assign RDATA = DRIVE ? rdata_q : 8'h00;

endmodule
